// File: rtl/canonical_code_size_generator_pkg.sv
// Shared defaults, others-chain sentinel and FSM states
// for the canonical code-size generator.
package canonical_code_size_generator_pkg;

  localparam int DEF_SYMBOLS = 16;
  localparam int DEF_FREQ_WIDTH = 5;
  localparam int DEF_CODE_SIZE_WIDTH = 5;
  localparam int DEF_SYMBOL_ID_WIDTH = 5;

  // End of an others[] chain; low bits are sliced
  // to the symbol-id width.
  localparam logic [31:0] NONE = '1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    FIND_V1,
    FIND_V2,
    MERGE,
    INC_V1,
    INC_V2,
    SORT,
    DONE
  } state_t;

endpackage

// File: rtl/canonical_code_size_generator_min_freq_scanner.sv
// Sequential least-nonzero frequency search, one symbol per
// cycle, ties to the larger index, optional excluded index.
// Ports: clk, rst, start, freq_flat (entry i at [i*WW +: WW]),
//        exclude_en/exclude_idx, found, min_idx, scan_done.
module min_freq_scanner #(
  parameter int SYMBOLS = 16,
  parameter int WW = 9,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SYMBOLS*WW-1:0] freq_flat,
  input  logic              exclude_en,
  input  logic [AW-1:0]     exclude_idx,
  output logic              found,
  output logic [AW-1:0]     min_idx,
  output logic              scan_done
);

  localparam logic [AW-1:0] LAST = AW'(SYMBOLS - 1);

  logic          busy;
  logic [AW-1:0] idx;
  logic [WW-1:0] best;
  logic [WW-1:0] cur;
  logic          skip;

  always_comb begin
    cur  = freq_flat[idx*WW +: WW];
    skip = exclude_en && (idx == exclude_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      idx       <= '0;
      best      <= '0;
      found     <= 1'b0;
      min_idx   <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        idx     <= '0;
        best    <= '0;
        found   <= 1'b0;
        min_idx <= '0;
      end else if (busy) begin
        // <= lets a later equal entry win the tie
        if (cur != '0 && !skip &&
            (!found || cur <= best)) begin
          found   <= 1'b1;
          best    <= cur;
          min_idx <= idx;
        end
        if (idx == LAST) begin
          busy      <= 1'b0;
          scan_done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/canonical_code_size_generator.sv
// Huffman code sizes for a build-time frequency table, then
// canonical symbol order (by size, then index; size 0 last).
// Ports: clk, reset (async high), start, code_size_array,
//        sorted_symbols_final (both MSB-first), done.
module canonical_code_size_generator
  import canonical_code_size_generator_pkg::*;
#(
  parameter int SYMBOLS = DEF_SYMBOLS,
  parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
  parameter int CODE_SIZE_WIDTH = DEF_CODE_SIZE_WIDTH,
  parameter int SYMBOL_ID_WIDTH = DEF_SYMBOL_ID_WIDTH,
  parameter logic [SYMBOLS*FREQ_WIDTH-1:0] FREQ_INIT =
    {SYMBOLS{FREQ_WIDTH'(1)}}
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]
               code_size_array,
  output logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]
               sorted_symbols_final,
  output logic done
);

  localparam int AW = $clog2(SYMBOLS);
  localparam int WW = FREQ_WIDTH + AW;
  localparam int CW = CODE_SIZE_WIDTH;
  localparam int IW = SYMBOL_ID_WIDTH;
  localparam logic [IW-1:0] NONE_ID = NONE[IW-1:0];
  localparam logic [AW-1:0] LAST = AW'(SYMBOLS - 1);
  localparam logic [CW-1:0] MAX_LEN = CW'(SYMBOLS - 1);

  state_t        state;
  logic [WW-1:0] freq      [SYMBOLS];
  logic [CW-1:0] code_size [SYMBOLS];
  logic [IW-1:0] others    [SYMBOLS];
  logic [IW-1:0] sorted    [SYMBOLS];

  logic [AW-1:0] v1, v2, node, tail;
  logic [AW-1:0] sort_idx, sort_pos;
  logic [CW-1:0] sort_len;

  logic          scan_start;
  logic          scan_found;
  logic          scan_done;
  logic [AW-1:0] scan_idx;
  logic          sort_hit;

  logic [SYMBOLS*WW-1:0] freq_flat;
  logic [SYMBOLS*CW-1:0] size_next;
  logic [SYMBOLS*IW-1:0] sorted_next;

  always_comb begin
    freq_flat   = '0;
    size_next   = '0;
    sorted_next = '0;
    sort_hit    = code_size[sort_idx] == sort_len;
    for (int i = 0; i < SYMBOLS; i++) begin
      freq_flat[i*WW +: WW] = freq[i];
      size_next[(SYMBOLS-i)*CW-1 -: CW] = code_size[i];
      sorted_next[(SYMBOLS-i)*IW-1 -: IW] = sorted[i];
      // fold in the append made on the final sort cycle
      if (state == SORT && sort_hit &&
          sort_pos == AW'(i))
        sorted_next[(SYMBOLS-i)*IW-1 -: IW] =
          IW'(sort_idx);
    end
  end

  min_freq_scanner #(
    .SYMBOLS (SYMBOLS),
    .WW      (WW),
    .AW      (AW)
  ) u_scan (
    .clk         (clk),
    .rst         (reset),
    .start       (scan_start),
    .freq_flat   (freq_flat),
    .exclude_en  (state == FIND_V2),
    .exclude_idx (v1),
    .found       (scan_found),
    .min_idx     (scan_idx),
    .scan_done   (scan_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      done                 <= 1'b0;
      code_size_array      <= '0;
      sorted_symbols_final <= '0;
      scan_start           <= 1'b0;
      v1                   <= '0;
      v2                   <= '0;
      node                 <= '0;
      tail                 <= '0;
      sort_idx             <= '0;
      sort_pos             <= '0;
      sort_len             <= '0;
      for (int i = 0; i < SYMBOLS; i++) begin
        freq[i]      <= '0;
        code_size[i] <= '0;
        others[i]    <= NONE_ID;
        sorted[i]    <= '0;
      end
    end else begin
      scan_start <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= INIT;
            done  <= 1'b0;
          end
        end
        INIT: begin
          for (int i = 0; i < SYMBOLS; i++) begin
            freq[i] <= WW'(FREQ_INIT[
              (SYMBOLS-i)*FREQ_WIDTH-1 -: FREQ_WIDTH]);
            code_size[i] <= '0;
            others[i]    <= NONE_ID;
          end
          state      <= FIND_V1;
          scan_start <= 1'b1;
        end
        FIND_V1: begin
          if (scan_done) begin
            if (scan_found) begin
              v1         <= scan_idx;
              state      <= FIND_V2;
              scan_start <= 1'b1;
            end else begin
              state    <= SORT;
              sort_len <= CW'(1);
              sort_idx <= '0;
              sort_pos <= '0;
            end
          end
        end
        FIND_V2: begin
          if (scan_done) begin
            if (scan_found) begin
              v2    <= scan_idx;
              state <= MERGE;
            end else begin
              // a lone symbol that was never merged
              if (code_size[v1] == '0)
                code_size[v1] <= CW'(1);
              state    <= SORT;
              sort_len <= CW'(1);
              sort_idx <= '0;
              sort_pos <= '0;
            end
          end
        end
        MERGE: begin
          freq[v1] <= freq[v1] + freq[v2];
          freq[v2] <= '0;
          node     <= v1;
          state    <= INC_V1;
        end
        INC_V1: begin
          code_size[node] <= code_size[node] + 1'b1;
          if (others[node] == NONE_ID) begin
            tail  <= node;
            node  <= v2;
            state <= INC_V2;
          end else begin
            node <= AW'(others[node]);
          end
        end
        INC_V2: begin
          code_size[node] <= code_size[node] + 1'b1;
          if (others[node] == NONE_ID) begin
            others[tail] <= IW'(v2);
            state        <= FIND_V1;
            scan_start   <= 1'b1;
          end else begin
            node <= AW'(others[node]);
          end
        end
        SORT: begin
          // passes L = 1..SYMBOLS-1, then a final L = 0 pass
          if (sort_hit) begin
            sorted[sort_pos] <= IW'(sort_idx);
            sort_pos         <= sort_pos + 1'b1;
          end
          if (sort_idx == LAST) begin
            sort_idx <= '0;
            if (sort_len == '0) begin
              state                <= DONE;
              done                 <= 1'b1;
              code_size_array      <= size_next;
              sorted_symbols_final <= sorted_next;
            end else if (sort_len == MAX_LEN) begin
              sort_len <= '0;
            end else begin
              sort_len <= sort_len + 1'b1;
            end
          end else begin
            sort_idx <= sort_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canonical_code_size_generator.sv
// Directed bench: four table variants, reset, restart,
// busy-start and mid-merge reset.
module tb_canonical_code_size_generator;
  import canonical_code_size_generator_pkg::*;

  localparam logic [79:0] T_SKEW =
    {5'd8, 5'd4, 5'd2, 5'd1, 5'd1, 55'd0};
  localparam logic [79:0] T_TWO =
    {15'd0, 5'd5, 25'd0, 5'd7, 30'd0};
  localparam logic [79:0] T_ONE =
    {30'd0, 5'd3, 45'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  logic [79:0] cs_def, cs_skew, cs_two, cs_one;
  logic [79:0] so_def, so_skew, so_two, so_one;
  logic d_def, d_skew, d_two, d_one;
  logic [3:0] dones;

  int checks = 0;
  int errors = 0;

  int sz_def [16];
  int sz_skew[16];
  int sz_two [16];
  int sz_one [16];
  int or_seq [16];
  int or_two [16];
  int or_one [16];

  assign dones = {d_def, d_skew, d_two, d_one};

  always #5 clk = ~clk;

  canonical_code_size_generator u_def (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .code_size_array      (cs_def),
    .sorted_symbols_final (so_def),
    .done                 (d_def)
  );

  canonical_code_size_generator #(
    .FREQ_INIT (T_SKEW)
  ) u_skew (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .code_size_array      (cs_skew),
    .sorted_symbols_final (so_skew),
    .done                 (d_skew)
  );

  canonical_code_size_generator #(
    .FREQ_INIT (T_TWO)
  ) u_two (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .code_size_array      (cs_two),
    .sorted_symbols_final (so_two),
    .done                 (d_two)
  );

  canonical_code_size_generator #(
    .FREQ_INIT (T_ONE)
  ) u_one (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .code_size_array      (cs_one),
    .sorted_symbols_final (so_one),
    .done                 (d_one)
  );

  function automatic logic [79:0] pack(input int v[16]);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[(16-i)*5-1 -: 5] = 5'(v[i]);
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [79:0] got,
                       input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (dones != 4'hf && n < 4096) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, 80'(dones), 80'hf);
  endtask

  task automatic check_all(input string tag);
    check({tag, " def size"}, cs_def, pack(sz_def));
    check({tag, " def ord"}, so_def, pack(or_seq));
    check({tag, " skew size"}, cs_skew, pack(sz_skew));
    check({tag, " skew ord"}, so_skew, pack(or_seq));
    check({tag, " two size"}, cs_two, pack(sz_two));
    check({tag, " two ord"}, so_two, pack(or_two));
    check({tag, " one size"}, cs_one, pack(sz_one));
    check({tag, " one ord"}, so_one, pack(or_one));
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 16; i++) begin
      sz_def[i]  = 4;
      sz_skew[i] = 0;
      sz_two[i]  = 0;
      sz_one[i]  = 0;
      or_seq[i]  = i;
    end
    sz_skew[0] = 1;
    sz_skew[1] = 2;
    sz_skew[2] = 3;
    sz_skew[3] = 4;
    sz_skew[4] = 4;
    sz_two[3]  = 1;
    sz_two[9]  = 1;
    sz_one[6]  = 1;
    or_two = '{3, 9, 0, 1, 2, 4, 5, 6,
               7, 8, 10, 11, 12, 13, 14, 15};
    or_one = '{6, 0, 1, 2, 3, 4, 5, 7,
               8, 9, 10, 11, 12, 13, 14, 15};

    repeat (3) @(negedge clk);
    check("rst done", 80'(dones), 80'h0);
    check("rst size", cs_def, 80'h0);
    check("rst ord", so_two, 80'h0);
    reset = 1'b0;

    // first run, with a start pulse while busy
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("run1 done");
    check_all("run1");

    // restart from DONE: done drops, outputs hold
    pulse_start();
    check("done fall", 80'(dones), 80'h0);
    repeat (20) @(negedge clk);
    check("hold size", cs_skew, pack(sz_skew));
    check("hold ord", so_two, pack(or_two));
    wait_done("run2 done");
    check_all("run2");

    // reset while u_def is in MERGE
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (u_def.state == MERGE) seen = 1'b1;
    end
    check("merge seen", 80'(seen), 80'd1);
    reset = 1'b1;
    #1;
    check("mid rst done", 80'(dones), 80'h0);
    check("mid rst size", cs_def, 80'h0);
    check("mid rst ord", so_one, 80'h0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start();
    wait_done("run3 done");
    check_all("run3");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/canonical_code_size_generator.md
# canonical_code_size_generator

Computes Huffman code lengths for a fixed 16-symbol alphabet whose frequencies come from a build-time table. Uses the JPEG Annex K code-size procedure: repeatedly merge the two least-frequent live nodes, tracking per-symbol code sizes and "others" chains. Then emits symbols in canonical order: by code size, then by index. It is the front end of the canonical Huffman encoder; the code-assignment stage consumes its outputs.

## Interface
Parameters:
- SYMBOLS, 16: alphabet size.
- FREQ_WIDTH, 5: bits per table frequency.
- CODE_SIZE_WIDTH, 5: bits per code-size field.
- SYMBOL_ID_WIDTH, 5: bits per symbol-index field.
- FREQ_INIT, all ones: packed SYMBOLS×FREQ_WIDTH frequency table. Symbol 0 is in the most-significant field.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled in IDLE or DONE.
- code_size_array  out  SYMBOLS*CODE_SIZE_WIDTH  code size of symbol i at bits [(SYMBOLS-i)*W-1 -: W]. Symbol 0 is MSB-first.
- sorted_symbols_final  out  SYMBOLS*SYMBOL_ID_WIDTH  canonical order. Entry k is at bits [(SYMBOLS-k)*W-1 -: W].
- done  out  1  high when outputs are valid.

## Operation
- Working frequencies are FREQ_WIDTH+clog2(SYMBOLS) bits wide (9 at defaults), so merged sums cannot overflow.
- **INIT:** load the working frequencies from FREQ_INIT, clear all code sizes to 0, and set every others[i] = none.
- **FIND_V1:** scan all symbols for the least nonzero frequency. On a tie, take the larger index. If no node is found, go to SORT.
- **FIND_V2:** same scan, excluding v1. If no node is found, go to SORT.
- **MERGE:** freq[v1] += freq[v2], then freq[v2] = 0.
- **INC_V1:** increment code_size along v1's others chain, one node per cycle.
- **INC_V2:** do the same along v2's chain. Then link the tail of v1's chain to v2.
- After INC_V2, return to FIND_V1.
- **Single nonzero symbol:** that symbol gets code size 1.
- Symbols with zero frequency keep code size 0.
- There is no length limiting. A code size can reach SYMBOLS-1 and must fit in CODE_SIZE_WIDTH.
- **SORT:** for L = 1..SYMBOLS-1, scan symbols 0..SYMBOLS-1 in ascending order. Append each symbol whose size equals L.
- After SORT, append the size-0 symbols in ascending index order.
- **DONE:** register both output vectors and assert done.
- States: IDLE → INIT → FIND_V1 ⇄ FIND_V2 → MERGE → INC_V1 → INC_V2 → FIND_V1 … → SORT → DONE.
- DONE → INIT on start.

## Timing
- **Reset values:** done=0, code_size_array=0, sorted_symbols_final=0, state=IDLE. Reset takes effect immediately at any point, including mid-computation.
- start is accepted only in IDLE or DONE, and is ignored while busy.
- done falls the cycle after start is accepted.
- Latency from start to done must not exceed 4096 cycles at defaults.
- Each scan costs one cycle per symbol; chain walks cost one cycle per node.
- Outputs change only on entry to DONE. They hold stable while done=1 and through the following computation, until the next DONE.
- start is a pulse. Holding it high in DONE restarts a computation each time it is accepted.

## Structure
- **Shared package:** default parameter values, the NONE sentinel for others[], and the FSM state enum.
- **Optional sub-module:** `min_freq_scanner` (sequential least-nonzero search with tie toward the larger index and an exclude input), used for both FIND_V1 and FIND_V2.
- Everything else lives in one module.

## Test plan
- **Default table (16 ones):** reset, pulse start → done; all code sizes 4; sorted = 0,1,…,15.
- **Skewed table:** FREQ_INIT = {8,4,2,1,1, rest 0} → sizes 1,2,3,4,4 then zeros; sorted = 0,1,2,3,4,5,…,15.
- **Two symbols:** FREQ_INIT with symbol 3 = 5, symbol 9 = 7, others 0 → sizes[3]=sizes[9]=1, all others 0; sorted = 3,9,0,1,2,4,5,6,7,8,10,…,15.
- **Single symbol:** only symbol 6 nonzero → size[6]=1, all others 0; sorted starts with 6, followed by the remaining indices ascending.
- **Reset mid-run:** assert reset during MERGE → done=0, outputs 0. Deassert reset and pulse start → same result as a clean run.
- **Restart and busy-start:** a start pulsed while busy is ignored. A second start after done reproduces identical outputs. done must deassert and reassert within 4096 cycles.
